// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the multi-port register file.
package regfile_pkg;

  localparam int unsigned DEF_DW    = 32;
  localparam int unsigned DEF_AW    = 5;
  localparam int unsigned ZERO_ADDR = 0;

  // Low bit of lane idx inside a packed vector of width-bit lanes
  function automatic int slice_lo(input int idx, input int width);
    return idx * width;
  endfunction

endpackage

// File: rtl/regfile_rdport.sv
// One read port: register/bypass data select, zero-register forcing, busy masking.
module regfile_rdport
  import regfile_pkg::*;
#(
  parameter int unsigned DW       = DEF_DW,
  parameter int unsigned AW       = DEF_AW,
  parameter bit          BYPASS   = 1'b1,
  parameter bit          ZERO_REG = 1'b1
) (
  input  logic [AW-1:0] rd_addr_i,
  input  logic [DW-1:0] reg_data_i,
  input  logic          reg_busy_i,
  input  logic          wr0_en_i,
  input  logic [AW-1:0] wr0_addr_i,
  input  logic [DW-1:0] wr0_data_i,
  input  logic          wr1_en_i,
  input  logic [AW-1:0] wr1_addr_i,
  input  logic [DW-1:0] wr1_data_i,
  output logic [DW-1:0] rd_data_o,
  output logic          rd_busy_o
);

  logic is_zero;
  logic hit0;
  logic hit1;

  // Write enables arrive already qualified against the zero register
  always_comb begin
    is_zero   = ZERO_REG && (rd_addr_i == AW'(ZERO_ADDR));
    hit0      = BYPASS && wr0_en_i && (wr0_addr_i == rd_addr_i);
    hit1      = BYPASS && wr1_en_i && (wr1_addr_i == rd_addr_i);
    rd_data_o = reg_data_i;
    rd_busy_o = reg_busy_i;
    if (is_zero) begin
      rd_data_o = '0;
      rd_busy_o = 1'b0;
    end else if (hit1) begin
      rd_data_o = wr1_data_i;
      rd_busy_o = 1'b0;
    end else if (hit0) begin
      rd_data_o = wr0_data_i;
      rd_busy_o = 1'b0;
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file: two write ports (WB, LR), NRD read ports with
// optional write-through bypass, and a per-register pending-write scoreboard.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int unsigned DW       = DEF_DW,
  parameter int unsigned AW       = DEF_AW,
  parameter int unsigned NRD      = 2,
  parameter bit          BYPASS   = 1'b1,
  parameter bit          ZERO_REG = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NRD*AW-1:0] rd_addr_i,
  output logic [NRD*DW-1:0] rd_data_o,
  output logic [NRD-1:0]    rd_busy_o,
  input  logic              wr0_en_i,
  input  logic [AW-1:0]     wr0_addr_i,
  input  logic [DW-1:0]     wr0_data_i,
  input  logic              wr1_en_i,
  input  logic [AW-1:0]     wr1_addr_i,
  input  logic [DW-1:0]     wr1_data_i,
  input  logic              set_en_i,
  input  logic [AW-1:0]     set_addr_i
);

  localparam int unsigned DEPTH = 1 << AW;

  logic [DW-1:0]    regs_q [DEPTH];
  logic [DW-1:0]    regs_d [DEPTH];
  logic [DEPTH-1:0] busy_q;
  logic [DEPTH-1:0] busy_d;
  logic             wr0_act;
  logic             wr1_act;

  // Writes to the hardwired zero register are dropped before anything sees them
  always_comb begin
    wr0_act = wr0_en_i && !(ZERO_REG && (wr0_addr_i == AW'(ZERO_ADDR)));
    wr1_act = wr1_en_i && !(ZERO_REG && (wr1_addr_i == AW'(ZERO_ADDR)));
  end

  // LR is applied after WB so it wins a same-address collision
  always_comb begin
    regs_d = regs_q;
    if (wr0_act) regs_d[wr0_addr_i] = wr0_data_i;
    if (wr1_act) regs_d[wr1_addr_i] = wr1_data_i;
  end

  // Set is applied after clears: a newly issued producer keeps the register pending
  always_comb begin
    busy_d = busy_q;
    if (wr0_act) busy_d[wr0_addr_i] = 1'b0;
    if (wr1_act) busy_d[wr1_addr_i] = 1'b0;
    if (set_en_i) busy_d[set_addr_i] = 1'b1;
    if (ZERO_REG) busy_d[ZERO_ADDR] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regs_q <= '{default: '0};
    end else begin
      regs_q <= regs_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [AW-1:0] addr;
    assign addr = rd_addr_i[slice_lo(k, AW) +: AW];

    regfile_rdport #(
      .DW       (DW),
      .AW       (AW),
      .BYPASS   (BYPASS),
      .ZERO_REG (ZERO_REG)
    ) u_rdport (
      .rd_addr_i  (addr),
      .reg_data_i (regs_q[addr]),
      .reg_busy_i (busy_q[addr]),
      .wr0_en_i   (wr0_act),
      .wr0_addr_i (wr0_addr_i),
      .wr0_data_i (wr0_data_i),
      .wr1_en_i   (wr1_act),
      .wr1_addr_i (wr1_addr_i),
      .wr1_data_i (wr1_data_i),
      .rd_data_o  (rd_data_o[slice_lo(k, DW) +: DW]),
      .rd_busy_o  (rd_busy_o[k])
    );
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: a bypassing/zero-reg instance and a plain instance
// share stimulus; directed checks plus random traffic against a reference model.
module tb_regfile_mp;

  localparam int unsigned DW    = 32;
  localparam int unsigned AW    = 5;
  localparam int unsigned NRD   = 4;
  localparam int unsigned DEPTH = 32;

  logic              clk;
  logic              rst_n;
  logic [NRD*AW-1:0] rd_addr;
  logic [NRD*DW-1:0] rd_data_b, rd_data_n;
  logic [NRD-1:0]    rd_busy_b, rd_busy_n;
  logic              wr0_en, wr1_en, set_en;
  logic [AW-1:0]     wr0_addr, wr1_addr, set_addr;
  logic [DW-1:0]     wr0_data, wr1_data;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference state: index 0 = BYPASS=1/ZERO_REG=1 instance, 1 = BYPASS=0/ZERO_REG=0
  logic [DW-1:0] mem [2][DEPTH];
  logic          bsy [2][DEPTH];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  regfile_mp #(.DW(DW), .AW(AW), .NRD(NRD), .BYPASS(1'b1), .ZERO_REG(1'b1)) dut_b (
    .clk(clk), .rst_n(rst_n), .rd_addr_i(rd_addr), .rd_data_o(rd_data_b), .rd_busy_o(rd_busy_b),
    .wr0_en_i(wr0_en), .wr0_addr_i(wr0_addr), .wr0_data_i(wr0_data),
    .wr1_en_i(wr1_en), .wr1_addr_i(wr1_addr), .wr1_data_i(wr1_data),
    .set_en_i(set_en), .set_addr_i(set_addr)
  );

  regfile_mp #(.DW(DW), .AW(AW), .NRD(NRD), .BYPASS(1'b0), .ZERO_REG(1'b0)) dut_n (
    .clk(clk), .rst_n(rst_n), .rd_addr_i(rd_addr), .rd_data_o(rd_data_n), .rd_busy_o(rd_busy_n),
    .wr0_en_i(wr0_en), .wr0_addr_i(wr0_addr), .wr0_data_i(wr0_data),
    .wr1_en_i(wr1_en), .wr1_addr_i(wr1_addr), .wr1_data_i(wr1_data),
    .set_en_i(set_en), .set_addr_i(set_addr)
  );

  function automatic bit byp(int c); return c == 0; endfunction
  function automatic bit zr(int c);  return c == 0; endfunction

  function automatic logic [DW-1:0] m_data(int c, int a);
    if (zr(c) && a == 0) return '0;
    if (byp(c) && wr1_en && int'(wr1_addr) == a) return wr1_data;
    if (byp(c) && wr0_en && int'(wr0_addr) == a) return wr0_data;
    return mem[c][a];
  endfunction

  function automatic logic m_busy(int c, int a);
    if (zr(c) && a == 0) return 1'b0;
    if (byp(c) && ((wr0_en && int'(wr0_addr) == a) || (wr1_en && int'(wr1_addr) == a))) return 1'b0;
    return bsy[c][a];
  endfunction

  function automatic logic [DW-1:0] d_data(int c, int k);
    return (c == 0) ? rd_data_b[k*DW +: DW] : rd_data_n[k*DW +: DW];
  endfunction

  function automatic logic d_busy(int c, int k);
    return (c == 0) ? rd_busy_b[k] : rd_busy_n[k];
  endfunction

  task automatic m_reset();
    for (int c = 0; c < 2; c++)
      for (int a = 0; a < DEPTH; a++) begin
        mem[c][a] = '0;
        bsy[c][a] = 1'b0;
      end
  endtask

  task automatic m_update();
    for (int c = 0; c < 2; c++) begin
      if (wr0_en && !(zr(c) && wr0_addr == 0)) begin
        mem[c][wr0_addr] = wr0_data;
        bsy[c][wr0_addr] = 1'b0;
      end
      if (wr1_en && !(zr(c) && wr1_addr == 0)) begin
        mem[c][wr1_addr] = wr1_data;
        bsy[c][wr1_addr] = 1'b0;
      end
      if (set_en && !(zr(c) && set_addr == 0)) bsy[c][set_addr] = 1'b1;
    end
  endtask

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    for (int c = 0; c < 2; c++)
      for (int k = 0; k < NRD; k++) begin
        int a;
        a = int'(rd_addr[k*AW +: AW]);
        chk($sformatf("dut%0d_data%0d_r%0d", c, k, a), d_data(c, k), m_data(c, a));
        chk($sformatf("dut%0d_busy%0d_r%0d", c, k, a), DW'(d_busy(c, k)), DW'(m_busy(c, a)));
      end
  endtask

  task automatic settle();
    @(negedge clk);
    check_all();
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst_n) m_update();
    #1;
  endtask

  task automatic idle();
    wr0_en = 1'b0; wr1_en = 1'b0; set_en = 1'b0;
  endtask

  task automatic rd(input int a0, input int a1, input int a2, input int a3);
    rd_addr = {AW'(a3), AW'(a2), AW'(a1), AW'(a0)};
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    wr0_addr = '0; wr1_addr = '0; set_addr = '0;
    wr0_data = '0; wr1_data = '0;
    rd(1, 2, 3, 4);
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    settle();
    chk("reset_busy_b", DW'(rd_busy_b), '0);
    tick();

    // Bypass: r7 written on WB while port 0 reads it
    rd(7, 0, 1, 2);
    wr0_en = 1'b1; wr0_addr = 5'd7; wr0_data = 32'h1234_5678;
    settle();
    chk("byp_same_cycle_b", d_data(0, 0), 32'h1234_5678);
    chk("byp_same_cycle_n", d_data(1, 0), 32'h0);
    tick();
    idle();
    settle();
    chk("byp_next_cycle_n", d_data(1, 0), 32'h1234_5678);
    tick();

    // Collision: LR beats WB on r3
    rd(0, 3, 3, 0);
    wr0_en = 1'b1; wr0_addr = 5'd3; wr0_data = 32'h1111;
    wr1_en = 1'b1; wr1_addr = 5'd3; wr1_data = 32'h2222;
    settle();
    chk("coll_byp_b", d_data(0, 1), 32'h2222);
    tick();
    idle();
    settle();
    chk("coll_after_b", d_data(0, 1), 32'h2222);
    chk("coll_after_n", d_data(1, 2), 32'h2222);
    tick();

    // Zero register: write and set on r0
    rd(0, 0, 1, 2);
    wr1_en = 1'b1; wr1_addr = 5'd0; wr1_data = 32'hFFFF_FFFF;
    set_en = 1'b1; set_addr = 5'd0;
    settle();
    chk("zero_data_b", d_data(0, 0), 32'h0);
    tick();
    idle();
    settle();
    chk("zero_data_after_b", d_data(0, 0), 32'h0);
    chk("zero_busy_after_b", DW'(rd_busy_b[0]), 32'h0);
    chk("r0_data_plain_n", d_data(1, 0), 32'hFFFF_FFFF);
    chk("r0_busy_plain_n", DW'(rd_busy_n[0]), 32'h1);
    tick();

    // Scoreboard on r9
    rd(9, 9, 0, 0);
    set_en = 1'b1; set_addr = 5'd9;
    settle();
    chk("sb_set_not_yet_b", DW'(rd_busy_b[0]), 32'h0);
    tick();
    idle();
    settle();
    chk("sb_set_vis_b", DW'(rd_busy_b[0]), 32'h1);
    chk("sb_set_vis_n", DW'(rd_busy_n[0]), 32'h1);
    tick();
    wr0_en = 1'b1; wr0_addr = 5'd9; wr0_data = 32'h99;
    settle();
    chk("sb_clr_mask_b", DW'(rd_busy_b[0]), 32'h0);
    chk("sb_clr_fwd_b", d_data(0, 0), 32'h99);
    chk("sb_clr_late_n", DW'(rd_busy_n[0]), 32'h1);
    tick();
    set_en = 1'b1; set_addr = 5'd9;
    wr0_data = 32'h55;
    settle();
    tick();
    idle();
    settle();
    chk("sb_set_wins_b", DW'(rd_busy_b[0]), 32'h1);
    chk("sb_set_wins_n", DW'(rd_busy_n[1]), 32'h1);
    chk("sb_set_wins_data_n", d_data(1, 0), 32'h55);
    tick();

    // Multi-port: distinct and shared addresses
    wr0_en = 1'b1; wr0_addr = 5'd1; wr0_data = 32'hA1;
    wr1_en = 1'b1; wr1_addr = 5'd2; wr1_data = 32'hA2;
    settle();
    tick();
    wr0_addr = 5'd3; wr0_data = 32'hA3;
    wr1_addr = 5'd4; wr1_data = 32'hA4;
    settle();
    tick();
    idle();
    rd(1, 2, 3, 4);
    settle();
    for (int k = 0; k < NRD; k++) begin
      chk($sformatf("mp_distinct_b%0d", k), d_data(0, k), DW'(32'hA1 + k));
      chk($sformatf("mp_distinct_n%0d", k), d_data(1, k), DW'(32'hA1 + k));
    end
    tick();
    rd(2, 2, 2, 2);
    settle();
    for (int k = 0; k < NRD; k++) chk($sformatf("mp_shared_b%0d", k), d_data(0, k), 32'hA2);
    tick();

    // Asynchronous reset: r5 loaded and pending, then cleared without an edge
    rd(5, 5, 0, 1);
    wr0_en = 1'b1; wr0_addr = 5'd5; wr0_data = 32'hDEAD_BEEF;
    set_en = 1'b1; set_addr = 5'd5;
    settle();
    tick();
    idle();
    settle();
    chk("pre_rst_data_n", d_data(1, 0), 32'hDEAD_BEEF);
    chk("pre_rst_busy_b", DW'(rd_busy_b[0]), 32'h1);
    rst_n = 1'b0;
    #1;
    m_reset();
    chk("rst_async_data_b", d_data(0, 0), 32'h0);
    chk("rst_async_data_n", d_data(1, 0), 32'h0);
    chk("rst_async_busy_b", DW'(rd_busy_b[0]), 32'h0);
    chk("rst_async_busy_n", DW'(rd_busy_n[0]), 32'h0);
    wr0_en = 1'b1; wr0_data = 32'h77;
    tick();
    idle();
    rst_n = 1'b1;
    settle();
    chk("rst_write_dropped_n", d_data(1, 0), 32'h0);
    tick();

    // Random traffic on a narrow address range to provoke collisions
    for (int i = 0; i < 300; i++) begin
      for (int k = 0; k < NRD; k++) rd_addr[k*AW +: AW] = AW'($urandom_range(0, 7));
      wr0_en   = 1'($urandom_range(0, 1));
      wr1_en   = 1'($urandom_range(0, 1));
      set_en   = 1'($urandom_range(0, 1));
      wr0_addr = AW'($urandom_range(0, 7));
      wr1_addr = AW'($urandom_range(0, 7));
      set_addr = AW'($urandom_range(0, 7));
      wr0_data = DW'($urandom);
      wr1_data = DW'($urandom);
      settle();
      tick();
    end
    idle();
    settle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
